// File: rtl/simplez_core.sv
// Simplez accumulator core: fetches 12-bit instructions and drives the
// address/write side of a falling-edge memory port.
module simplez_core #(
    parameter int            AW       = 9,
    parameter int            DW       = 12,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          halt,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] acc
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM_WR = 3'd3;
    localparam logic [2:0] S_MEM_RD = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;

    localparam logic [2:0] OP_ST   = 3'd0;
    localparam logic [2:0] OP_LD   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_BR   = 3'd3;
    localparam logic [2:0] OP_BZ   = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;
    localparam logic [2:0] OP_DEC  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          halt_q, halt_d;

    logic [2:0]    op;
    logic [AW-1:0] cd;

    assign op = ir_q[DW-1:DW-3];
    assign cd = ir_q[AW-1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        ir_d    = ir_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        // Strobe defaults low so it can only live for the MEM_WR cycle.
        we_d    = 1'b0;
        halt_d  = halt_q;
        case (state_q)
            S_FETCH: begin
                if (run) begin
                    addr_d  = pc_q;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                unique case (op)
                    OP_ST: begin
                        addr_d  = cd;
                        wdata_d = acc_q;
                        we_d    = 1'b1;
                        state_d = S_MEM_WR;
                    end
                    OP_LD, OP_ADD: begin
                        addr_d  = cd;
                        state_d = S_MEM_RD;
                    end
                    OP_BR:   pc_d = cd;
                    OP_BZ:   if (acc_q == '0) pc_d = cd;
                    OP_CLR:  acc_d = '0;
                    OP_DEC:  acc_d = acc_q - 1'b1;
                    OP_HALT: begin
                        halt_d  = 1'b1;
                        state_d = S_HALTED;
                    end
                endcase
            end
            S_MEM_WR: state_d = S_FETCH;
            S_MEM_RD: begin
                if (op == OP_LD) acc_d = mem_rdata;
                else             acc_d = acc_q + mem_rdata;
                state_d = S_FETCH;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            acc_q   <= '0;
            ir_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            halt_q  <= halt_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign halt      = halt_q;
    assign pc        = pc_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_simplez_core.sv
// Directed bench for simplez_core with a falling-edge memory model.
module tb_simplez_core;

    logic        clk;
    logic        rst;
    logic        run;
    logic [11:0] mem_rdata;
    logic [8:0]  mem_addr;
    logic [11:0] mem_wdata;
    logic        mem_we;
    logic        halt;
    logic [8:0]  pc;
    logic [11:0] acc;

    logic [11:0] mem [512];
    logic        clr_en;
    logic        ld_en;
    logic [8:0]  ld_addr;
    logic [11:0] ld_data;
    int          wr_cnt;

    int n_cmp;
    int n_bad;

    simplez_core #(.AW(9), .DW(12), .RESET_PC(9'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .halt      (halt),
        .pc        (pc),
        .acc       (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory samples address on the falling edge; bench loads share the port.
    always @(negedge clk) begin
        if (clr_en) begin
            for (int i = 0; i < 512; i++) mem[i] <= '0;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_reset();
        rst    = 1'b1;
        run    = 1'b0;
        clr_en = 1'b1;
        @(negedge clk);
        #1;
        clr_en = 1'b0;
    endtask

    task automatic ld(input logic [8:0] a, input logic [11:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(negedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic end_reset(input logic r);
        tick();
        rst = 1'b0;
        run = r;
    endtask

    task automatic run_halt(input int budget, input string tag);
        for (int i = 0; i < budget && halt !== 1'b1; i++) tick();
        check(tag, 32'(halt), 32'd1);
    endtask

    task automatic load_basic();
        ld(9'd0, 12'o1004);
        ld(9'd1, 12'o0005);
        ld(9'd2, 12'o7000);
        ld(9'd4, 12'o0123);
    endtask

    initial begin
        int we_n;
        int w0;
        logic [8:0] we_a;
        n_cmp   = 0;
        n_bad   = 0;
        wr_cnt  = 0;
        rst     = 1'b1;
        run     = 1'b0;
        clr_en  = 1'b0;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;

        // LD 4 / ST 5 / HALT
        begin_reset();
        load_basic();
        end_reset(1'b1);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        we_n = 0;
        we_a = '0;
        for (int i = 0; i < 13 && halt !== 1'b1; i++) begin
            tick();
            if (mem_we === 1'b1) begin
                we_n++;
                we_a = mem_addr;
            end
        end
        check("basic_halt", 32'(halt), 32'd1);
        check("basic_acc", 32'(acc), 32'o0123);
        check("basic_pc", 32'(pc), 32'd3);
        check("basic_mem5", 32'(mem[5]), 32'o0123);
        check("basic_we_n", 32'(we_n), 32'd1);
        check("basic_we_a", 32'(we_a), 32'd5);

        // HALT stickiness
        w0 = wr_cnt;
        for (int i = 0; i < 20; i++) begin
            run = i[0];
            tick();
        end
        check("hold_pc", 32'(pc), 32'd3);
        check("hold_acc", 32'(acc), 32'o0123);
        check("hold_we", 32'(mem_we), 32'd0);
        check("hold_halt", 32'(halt), 32'd1);
        check("hold_wr", 32'(wr_cnt - w0), 32'd0);
        begin_reset();
        end_reset(1'b0);
        check("unhalt", 32'(halt), 32'd0);

        // ADD wrap
        begin_reset();
        ld(9'd0, 12'o1020);
        ld(9'd1, 12'o2021);
        ld(9'd2, 12'o7000);
        ld(9'o020, 12'o7777);
        ld(9'o021, 12'o0002);
        end_reset(1'b1);
        run_halt(20, "add_halt");
        check("add_acc", 32'(acc), 32'o0001);
        check("add_pc", 32'(pc), 32'd3);

        // DEC from zero
        begin_reset();
        ld(9'd0, 12'o5000);
        ld(9'd1, 12'o6000);
        ld(9'd2, 12'o7000);
        end_reset(1'b1);
        run_halt(20, "dec_halt");
        check("dec_acc", 32'(acc), 32'o7777);

        // BZ taken
        begin_reset();
        ld(9'd0, 12'o5000);
        ld(9'd1, 12'o4010);
        ld(9'd2, 12'o7000);
        ld(9'o010, 12'o7000);
        end_reset(1'b1);
        for (int i = 0; i < 6; i++) tick();
        check("bz_t_pc", 32'(pc), 32'o010);
        run_halt(10, "bz_t_halt");
        check("bz_t_pc2", 32'(pc), 32'o011);

        // BZ not taken
        begin_reset();
        ld(9'd0, 12'o1004);
        ld(9'd1, 12'o4010);
        ld(9'd2, 12'o7000);
        ld(9'd4, 12'o0001);
        ld(9'o010, 12'o7000);
        end_reset(1'b1);
        run_halt(20, "bz_n_halt");
        check("bz_n_pc", 32'(pc), 32'd3);
        check("bz_n_acc", 32'(acc), 32'd1);

        // BR to top of memory, pc wraps
        begin_reset();
        ld(9'd0, 12'o3777);
        ld(9'o777, 12'o5000);
        end_reset(1'b1);
        for (int i = 0; i < 3; i++) tick();
        check("br_pc", 32'(pc), 32'o777);
        tick();
        check("br_addr", 32'(mem_addr), 32'o777);
        tick();
        check("br_wrap", 32'(pc), 32'd0);

        // run gating
        begin_reset();
        load_basic();
        end_reset(1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("idle_addr", 32'(mem_addr), 32'd0);
        check("idle_pc", 32'(pc), 32'd0);
        check("idle_acc", 32'(acc), 32'd0);
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("drop_acc", 32'(acc), 32'o0123);
        check("drop_pc", 32'(pc), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check("park_pc", 32'(pc), 32'd1);
        check("park_addr", 32'(mem_addr), 32'd4);
        check("park_we", 32'(mem_we), 32'd0);

        // Reset during MEM_WR
        begin_reset();
        load_basic();
        end_reset(1'b1);
        for (int i = 0; i < 7; i++) tick();
        check("mw_we", 32'(mem_we), 32'd1);
        check("mw_addr", 32'(mem_addr), 32'd5);
        w0  = wr_cnt;
        rst = 1'b1;
        run = 1'b0;
        tick();
        check("mw_rst_we", 32'(mem_we), 32'd0);
        check("mw_rst_pc", 32'(pc), 32'd0);
        check("mw_rst_acc", 32'(acc), 32'd0);
        check("mw_rst_halt", 32'(halt), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("mw_once", 32'((wr_cnt - w0) <= 1), 32'd1);
        check("mw_we_after", 32'(mem_we), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/simplez_core.md
Name: simplez_core

Overview:
- Bus initiator for the Simplez 12-bit instruction memory.
- Fetches instructions and executes them against a single accumulator.
- Drives the address, write-data and write-enable side of the memory port; the memory reads and writes on the falling clock edge.
- Sits between the memory block and the top level; exposes halt/PC/accumulator for LEDs and the bench.

Parameters:
- AW, 9, address width (512 words)
- DW, 12, data/instruction width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  input  1  system clock; all core state updates on rising edge
- rst  input  1  synchronous, active-high reset
- run  input  1  execution enable; sampled only in FETCH
- mem_rdata  input  DW  read data from memory (registered there on falling edge)
- mem_addr  output  AW  memory address, registered
- mem_wdata  output  DW  write data, registered
- mem_we  output  1  write strobe, registered, one cycle wide
- halt  output  1  high while in HALTED
- pc  output  AW  current program counter
- acc  output  DW  accumulator A

Behaviour:
- Reset (rst=1 at rising edge), regardless of current state:
  - pc=RESET_PC, acc=0, ir=0.
  - mem_addr=0, mem_wdata=0, mem_we=0, halt=0.
  - state=FETCH.
  - A write in flight is dropped: mem_we is low from that edge on.
- Instruction format: opcode = ir[11:9], CD = ir[8:0].
  - Opcodes: 0 ST, 1 LD, 2 ADD, 3 BR, 4 BZ, 5 CLR, 6 DEC, 7 HALT.
- Memory timing contract: mem_addr is set at rising edge t; memory samples it at the next falling edge; mem_rdata is valid at rising edge t+1. Writes use the same timing with mem_we=1.
- FETCH:
  - run=1: mem_addr<=pc, next state DECODE.
  - run=0: stay in FETCH, all registers hold.
- DECODE: ir<=mem_rdata, pc<=pc+1 (wraps 511->0), next state EXEC.
- EXEC, by opcode:
  - ST: mem_addr<=CD, mem_wdata<=acc, mem_we<=1, next MEM_WR.
  - LD/ADD: mem_addr<=CD, next MEM_RD.
  - BR: pc<=CD, next FETCH.
  - BZ: if acc==0 then pc<=CD, else pc unchanged; next FETCH.
  - CLR: acc<=0, next FETCH.
  - DEC: acc<=acc-1 modulo 2^DW (0 -> 0xFFF), next FETCH.
  - HALT: halt<=1, next HALTED.
- MEM_WR: mem_we<=0, next FETCH. mem_we is high for exactly one cycle.
- MEM_RD:
  - LD: acc<=mem_rdata.
  - ADD: acc<=(acc+mem_rdata) mod 2^DW; carry discarded, no flags.
  - Next FETCH.
- HALTED: all registers hold, halt=1; only rst exits.
- Cycle counts, FETCH to next FETCH with run=1:
  - BR/BZ/CLR/DEC: 3 cycles.
  - ST/LD/ADD: 4 cycles.
- pc shows the incremented value from the DECODE edge onward.
- mem_we is never high outside MEM_WR.
- mem_addr/mem_wdata hold their last values when not updated.
- run deasserted mid-instruction has no effect; the core stops at the next FETCH.
- Self-modifying code: an ST to the next instruction's address is seen by the next FETCH. The write completes at the falling edge before the next FETCH.

Test Plan:
- Reset, run=1; mem[0]=0o1004 (LD 4), mem[1]=0o0005 (ST 5), mem[2]=0o7000, mem[4]=0o0123 -> mem[5]=0o0123, acc=0o0123, halt=1 within 13 cycles, pc=3; mem_we high exactly 1 cycle with mem_addr=5.
- ADD wrap: acc preloaded by LD 0o7777, then ADD of a word 0o0002 -> acc=0o0001; DEC from acc=0 -> acc=0o7777.
- Branches:
  - CLR; BZ 0o010 -> pc=0o010.
  - LD nonzero; BZ 0o010 -> pc falls through.
  - BR 0o777 executes, then the instruction at 0o777 -> pc wraps to 0.
- run gating: run=0 after reset for 10 cycles -> mem_addr=0, pc=0, no state change. Drop run during a LD -> LD completes, core parks in FETCH.
- Reset mid-ST: assert rst in the MEM_WR cycle -> mem_we=0 at that edge, pc=0, acc=0, halt=0. Target word written at most once, never twice.
- HALT stickiness: after HALT, toggle run for 20 cycles -> pc/acc/mem_we unchanged, halt=1. Reset clears halt.
